// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings, controller state type and the default datapath width.
package hilo_muldiv_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the iterative datapath. Multiply does a
// shift-add on the {hi,lo} partial product (multiplier in lo, LSB first).
// Divide does a restoring shift-subtract with the remainder in hi and the
// dividend/quotient shifting through lo.
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compute both candidate updates and pick the one for the current operation
  always_comb begin
    add_sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    hi_out  = add_sum[WIDTH:1];
    lo_out  = {add_sum[0], lo_in[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH]) begin
        hi_out = shifted[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end else begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit. Operands are converted to
// magnitudes at start, WIDTH shift-add/subtract iterations run in CALC,
// and FIX applies signs, accumulation and the divide-by-zero result
// before writing the architectural HI/LO registers.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CNTW-1:0]   iter_q;
  logic [OPW-1:0]    op_q;
  logic [WIDTH-1:0]  a_q, opnd_q, work_hi_q, work_lo_q;
  logic              is_div_q, neg_a_q, neg_b_q;
  logic [WIDTH-1:0]  step_hi, step_lo;

  logic              in_mthi, in_mtlo, in_div, in_signed, in_calc;
  logic [WIDTH-1:0]  mag_a, mag_b;

  logic [2*WIDTH-1:0] prod, prod_adj, hilo_cur, mul_res;
  logic [WIDTH-1:0]   quo_adj, rem_adj, fix_hi, fix_lo;
  logic               div_zero, fix_dbz;

  assign in_mthi   = (op == OPW'(OP_MTHI));
  assign in_mtlo   = (op == OPW'(OP_MTLO));
  assign in_div    = (op == OPW'(OP_DIV)) || (op == OPW'(OP_DIVU));
  assign in_signed = (op == OPW'(OP_MULT)) || (op == OPW'(OP_MADD)) ||
                     (op == OPW'(OP_MSUB)) || (op == OPW'(OP_DIV));
  assign in_calc   = in_div || in_signed || (op == OPW'(OP_MULTU));
  assign mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;

  assign busy = (state_q != ST_IDLE);

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .hi_in   (work_hi_q),
    .lo_in   (work_lo_q),
    .operand (opnd_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always returns to idle, even over a new start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && in_calc) state_d = ST_CALC;
      ST_CALC: if (iter_q == LAST_ITER) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Final correction: signs, accumulate/subtract into HI/LO, divide by zero
  always_comb begin
    prod     = {work_hi_q, work_lo_q};
    prod_adj = (neg_a_q ^ neg_b_q) ? -prod : prod;
    hilo_cur = {hi, lo};
    mul_res  = prod_adj;
    if (op_q == OPW'(OP_MADD)) mul_res = hilo_cur + prod_adj;
    if (op_q == OPW'(OP_MSUB)) mul_res = hilo_cur - prod_adj;
    quo_adj  = (neg_a_q ^ neg_b_q) ? -work_lo_q : work_lo_q;
    rem_adj  = neg_a_q ? -work_hi_q : work_hi_q;
    div_zero = (opnd_q == '0);
    fix_dbz  = is_div_q && div_zero;
    {fix_hi, fix_lo} = mul_res;
    if (is_div_q) begin
      if (div_zero) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_adj;
        fix_lo = quo_adj;
      end
    end
  end

  // Operand capture, iteration, and the architectural HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q      <= '0;
      op_q        <= '0;
      a_q         <= '0;
      opnd_q      <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      is_div_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (!flush) begin
        unique case (state_q)
          ST_IDLE: begin
            if (start && in_calc) begin
              iter_q    <= '0;
              op_q      <= op;
              a_q       <= a;
              opnd_q    <= mag_b;
              work_hi_q <= '0;
              work_lo_q <= mag_a;
              is_div_q  <= in_div;
              neg_a_q   <= in_signed && a[WIDTH-1];
              neg_b_q   <= in_signed && b[WIDTH-1];
            end else if (start && in_mthi) begin
              hi   <= a;
              done <= 1'b1;
            end else if (start && in_mtlo) begin
              lo   <= a;
              done <= 1'b1;
            end
          end
          ST_CALC: begin
            work_hi_q <= step_hi;
            work_lo_q <= step_lo;
            iter_q    <= iter_q + CNTW'(1);
          end
          ST_FIX: begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= fix_dbz;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit at WIDTH=32: directed cases with literal
// results, then randomized start/flush/reset traffic against a timeline
// model that computes results with plain 64-bit arithmetic.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, MADD = 3'd2, MSUB = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  logic          clk, rst_n, start, flush;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int vectors = 0;
  int miscompares = 0;

  logic          m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0]  m_hi = '0, m_lo = '0;
  logic          pending = 1'b0;
  int            remaining = 0;
  logic [2:0]    p_op;
  logic [W-1:0]  p_a, p_b;

  hilo_muldiv_unit #(.WIDTH(W), .OPW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of a finished operation, from plain arithmetic
  task automatic model_complete(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sx, sy;
    logic [63:0] acc, ux, uy;
    int          qi, ri;
    sx = longint'(int'(x));
    sy = longint'(int'(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    acc = {m_hi, m_lo};
    m_dbz = 1'b0;
    case (o)
      MULT:  acc = sx * sy;
      MULTU: acc = ux * uy;
      MADD:  acc = acc + (sx * sy);
      MSUB:  acc = acc - (sx * sy);
      DIV: begin
        if (y == 0) begin
          acc = {x, 32'hFFFF_FFFF};
          m_dbz = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          acc = {32'd0, 32'h8000_0000};
        end else begin
          qi = int'(x) / int'(y);
          ri = int'(x) % int'(y);
          acc = {32'(ri), 32'(qi)};
        end
      end
      DIVU: begin
        if (y == 0) begin
          acc = {x, 32'hFFFF_FFFF};
          m_dbz = 1'b1;
        end else begin
          acc = {x % y, x / y};
        end
      end
      default: ;
    endcase
    m_hi = acc[63:32];
    m_lo = acc[31:0];
  endtask

  // Timeline model: an accepted operation completes W+1 edges later
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0;
        pending = 0; remaining = 0;
      end else begin
        m_done = 0;
        m_dbz  = 0;
        if (flush) begin
          pending = 0;
          m_busy  = 0;
        end else if (pending) begin
          remaining--;
          if (remaining == 0) begin
            model_complete(p_op, p_a, p_b);
            pending = 0;
            m_busy  = 0;
            m_done  = 1;
          end
        end else if (start) begin
          if (op == MTHI) begin
            m_hi = a; m_done = 1;
          end else if (op == MTLO) begin
            m_lo = a; m_done = 1;
          end else begin
            pending = 1; remaining = W + 1; m_busy = 1;
            p_op = op; p_a = a; p_b = b;
          end
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  initial begin
    forever begin
      @(negedge clk);
      check_output("busy", busy, m_busy);
      check_output("done", done, m_done);
      check_output("hi", hi, m_hi);
      check_output("lo", lo, m_lo);
      check_output("div_by_zero", div_by_zero, m_dbz);
    end
  end

  // Drive one start pulse; returns #1 after the accepting edge
  task automatic apply_stimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_done: actual done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic watch_no_done(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Directed sequences with hand-computed results, then random traffic
  initial begin
    int cyc, dones;
    rst_n = 0; start = 0; flush = 0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hi", hi, 0);
    check_output("reset_lo", lo, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    rst_n = 1;
    @(posedge clk); #1;

    apply_stimulus(MULT, -32'sd3, 32'd7);
    check_output("mult_busy", busy, 1);
    wait_done(cyc);
    check_output("mult_latency", cyc, 33);
    check_output("mult_hi", hi, 32'hFFFF_FFFF);
    check_output("mult_lo", lo, 32'hFFFF_FFEB);

    apply_stimulus(MTHI, 32'd0, 32'd9);
    wait_done(cyc);
    check_output("mthi_latency", cyc, 0);
    apply_stimulus(MTLO, 32'd10, 32'd9);
    wait_done(cyc);
    apply_stimulus(MADD, 32'd4, 32'd5);
    wait_done(cyc);
    check_output("madd_lo", lo, 32'h1E);
    apply_stimulus(MSUB, 32'd2, 32'd3);
    wait_done(cyc);
    check_output("msub_lo", lo, 32'h18);
    check_output("msub_hi", hi, 32'h0);

    apply_stimulus(DIV, -32'sd7, 32'd2);
    wait_done(cyc);
    check_output("div_lo", lo, 32'hFFFF_FFFD);
    check_output("div_hi", hi, 32'hFFFF_FFFF);
    apply_stimulus(DIV, 32'd7, -32'sd2);
    wait_done(cyc);
    check_output("div_negb_lo", lo, 32'hFFFF_FFFD);
    check_output("div_negb_hi", hi, 32'h1);
    apply_stimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check_output("div_ovf_lo", lo, 32'h8000_0000);
    check_output("div_ovf_hi", hi, 32'h0);
    apply_stimulus(DIVU, 32'd7, 32'd0);
    wait_done(cyc);
    check_output("div0_latency", cyc, 33);
    check_output("div0_lo", lo, 32'hFFFF_FFFF);
    check_output("div0_hi", hi, 32'h7);
    check_output("div0_flag", div_by_zero, 1);

    apply_stimulus(DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    check_output("divu_lo", lo, 32'hE);
    check_output("divu_hi", hi, 32'h2);
    apply_stimulus(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc);
    check_output("b2b_latency", cyc, 33);
    check_output("multu_hi", hi, 32'h1);
    check_output("multu_lo", lo, 32'hFFFF_FFFE);

    apply_stimulus(MTHI, 32'h11, 32'd0);
    wait_done(cyc);
    apply_stimulus(MTLO, 32'h22, 32'd0);
    wait_done(cyc);
    apply_stimulus(MULT, 32'd5, 32'd6);
    repeat (2) @(posedge clk);
    #1;
    start = 1; op = MTHI; a = 32'hDEAD;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check_output("flush_busy", busy, 0);
    watch_no_done(40, dones);
    check_output("flush_no_done", dones, 0);
    check_output("flush_hi", hi, 32'h11);
    check_output("flush_lo", lo, 32'h22);

    start = 1; flush = 1; op = MTHI; a = 32'h77;
    @(posedge clk); #1;
    start = 0; flush = 0;
    check_output("flush_over_start_hi", hi, 32'h11);

    apply_stimulus(MULT, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    watch_no_done(40, dones);
    check_output("reset_no_done", dones, 0);
    check_output("reset_mid_hi", hi, 0);
    check_output("reset_mid_lo", lo, 0);
    apply_stimulus(MULT, 32'd3, 32'd4);
    wait_done(cyc);
    check_output("post_reset_latency", cyc, 33);
    check_output("post_reset_lo", lo, 32'd12);

    for (int c = 0; c < 20000; c++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick_operand();
      b     = pick_operand();
      flush = ($urandom_range(0, 149) == 0);
      rst_n = !(rst_n && $urandom_range(0, 2999) == 0);
      @(posedge clk); #1;
    end
    start = 0; flush = 0; rst_n = 1;
    repeat (40) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
